// File: rtl/control_sequencer.sv
// ============================================================================
//  Module      : control_sequencer
//  Description : T-state ring sequencer and microcode decode for an
//                accumulator machine (fetch T1..T3, execute T4..T6, halt).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
    parameter int OP_W      = 4,
    parameter int EARLY_END = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [OP_W-1:0] op_code,
    input  logic            zero_flag,
    output logic [5:0]      t_state,
    output logic            pc_out,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            mar_load,
    output logic            ram_out,
    output logic            ram_write,
    output logic            ir_load,
    output logic            ir_out,
    output logic            a_load,
    output logic            a_out,
    output logic            b_load,
    output logic            alu_out,
    output logic            alu_sub,
    output logic            out_load,
    output logic            halt,
    output logic            illegal
);

    localparam bit c_EARLY = (EARLY_END != 0);

    localparam logic [3:0] c_OP_LDA = 4'h0;
    localparam logic [3:0] c_OP_ADD = 4'h1;
    localparam logic [3:0] c_OP_SUB = 4'h2;
    localparam logic [3:0] c_OP_STA = 4'h3;
    localparam logic [3:0] c_OP_JMP = 4'h4;
    localparam logic [3:0] c_OP_JZ  = 4'h5;
    localparam logic [3:0] c_OP_OUT = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    // One-hot T-states; HALTED lives outside the ring so t_state reads zero.
    typedef enum logic [6:0] {
        ST_T1     = 7'b0000001,
        ST_T2     = 7'b0000010,
        ST_T3     = 7'b0000100,
        ST_T4     = 7'b0001000,
        ST_T5     = 7'b0010000,
        ST_T6     = 7'b0100000,
        ST_HALTED = 7'b1000000
    } state_t;

    state_t r_state;

    logic       w_upper_zero;
    logic [3:0] w_op_lo;
    logic       w_lda, w_add, w_sub, w_sta, w_jmp, w_jz, w_out, w_hlt;
    logic       w_illegal_op;
    logic       w_active;

    generate
        if (OP_W > 4) begin : g_wide_op
            assign w_upper_zero = ~|op_code[OP_W-1:4];
        end else begin : g_narrow_op
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    assign w_op_lo = op_code[3:0];

    assign w_lda = w_upper_zero && (w_op_lo == c_OP_LDA);
    assign w_add = w_upper_zero && (w_op_lo == c_OP_ADD);
    assign w_sub = w_upper_zero && (w_op_lo == c_OP_SUB);
    assign w_sta = w_upper_zero && (w_op_lo == c_OP_STA);
    assign w_jmp = w_upper_zero && (w_op_lo == c_OP_JMP);
    assign w_jz  = w_upper_zero && (w_op_lo == c_OP_JZ);
    assign w_out = w_upper_zero && (w_op_lo == c_OP_OUT);
    assign w_hlt = w_upper_zero && (w_op_lo == c_OP_HLT);

    assign w_illegal_op = !(w_lda || w_add || w_sub || w_sta ||
                            w_jmp || w_jz  || w_out || w_hlt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_T1;
        end else if (r_state == ST_HALTED) begin
            r_state <= ST_HALTED;
        end else if (en) begin
            case (r_state)
                ST_T1: r_state <= ST_T2;
                ST_T2: r_state <= ST_T3;
                ST_T3: r_state <= ST_T4;
                ST_T4: begin
                    if (w_hlt)
                        r_state <= ST_HALTED;
                    else if (c_EARLY && (w_jmp || w_jz || w_out || w_illegal_op))
                        r_state <= ST_T1;
                    else
                        r_state <= ST_T5;
                end
                ST_T5: begin
                    if (c_EARLY && (w_lda || w_sta))
                        r_state <= ST_T1;
                    else
                        r_state <= ST_T6;
                end
                default: r_state <= ST_T1;
            endcase
        end
    end

    assign w_active = !rst && en && (r_state != ST_HALTED);
    assign t_state  = r_state[5:0];
    assign halt     = !rst && (r_state == ST_HALTED);
    assign illegal  = w_active && (r_state == ST_T4) && w_illegal_op;

    // Strobes are a pure decode so they line up with the cycle they control.
    always_comb begin
        pc_out    = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        mar_load  = 1'b0;
        ram_out   = 1'b0;
        ram_write = 1'b0;
        ir_load   = 1'b0;
        ir_out    = 1'b0;
        a_load    = 1'b0;
        a_out     = 1'b0;
        b_load    = 1'b0;
        alu_out   = 1'b0;
        alu_sub   = 1'b0;
        out_load  = 1'b0;
        if (w_active) begin
            case (r_state)
                ST_T1: begin
                    pc_out   = 1'b1;
                    mar_load = 1'b1;
                end
                ST_T2: pc_inc = 1'b1;
                ST_T3: begin
                    ram_out = 1'b1;
                    ir_load = 1'b1;
                end
                ST_T4: begin
                    if (w_lda || w_add || w_sub || w_sta) begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                    end
                    if (w_jmp || (w_jz && zero_flag)) begin
                        ir_out  = 1'b1;
                        pc_load = 1'b1;
                    end
                    if (w_out) begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                    end
                end
                ST_T5: begin
                    if (w_lda) begin
                        ram_out = 1'b1;
                        a_load  = 1'b1;
                    end
                    if (w_add || w_sub) begin
                        ram_out = 1'b1;
                        b_load  = 1'b1;
                    end
                    if (w_sta) begin
                        a_out     = 1'b1;
                        ram_write = 1'b1;
                    end
                end
                ST_T6: begin
                    if (w_add || w_sub) begin
                        alu_out = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = w_sub;
                    end
                end
                default: ;
            endcase
        end
    end

    a_pc_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(pc_inc && pc_load));
    a_ram_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(ram_out && ram_write));
    a_single_driver: assert property (@(posedge clk) disable iff (rst)
        $onehot0({pc_out, ram_out, ir_out, a_out, alu_out}));
    a_tstate_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(t_state));

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Directed bench for control_sequencer (three configurations).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    // Strobe vector bit order: pc_out .. out_load, MSB first.
    localparam logic [13:0] c_PC_OUT    = 14'd1 << 13;
    localparam logic [13:0] c_PC_INC    = 14'd1 << 12;
    localparam logic [13:0] c_PC_LOAD   = 14'd1 << 11;
    localparam logic [13:0] c_MAR_LOAD  = 14'd1 << 10;
    localparam logic [13:0] c_RAM_OUT   = 14'd1 << 9;
    localparam logic [13:0] c_RAM_WRITE = 14'd1 << 8;
    localparam logic [13:0] c_IR_LOAD   = 14'd1 << 7;
    localparam logic [13:0] c_IR_OUT    = 14'd1 << 6;
    localparam logic [13:0] c_A_LOAD    = 14'd1 << 5;
    localparam logic [13:0] c_A_OUT     = 14'd1 << 4;
    localparam logic [13:0] c_B_LOAD    = 14'd1 << 3;
    localparam logic [13:0] c_ALU_OUT   = 14'd1 << 2;
    localparam logic [13:0] c_ALU_SUB   = 14'd1 << 1;
    localparam logic [13:0] c_OUT_LOAD  = 14'd1 << 0;

    localparam logic [13:0] c_F1 = c_PC_OUT | c_MAR_LOAD;
    localparam logic [13:0] c_F2 = c_PC_INC;
    localparam logic [13:0] c_F3 = c_RAM_OUT | c_IR_LOAD;

    logic       clk;
    logic       rst;
    logic       en;
    logic       zero_flag;
    logic [4:0] op5;

    wire [13:0] s_a, s_b, s_c;
    wire [5:0]  t_a, t_b, t_c;
    wire        h_a, h_b, h_c;
    wire        il_a, il_b, il_c;

    int n_total = 0;
    int n_bad   = 0;

    control_sequencer #(.OP_W(4), .EARLY_END(1)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .op_code(op5[3:0]), .zero_flag(zero_flag),
        .t_state(t_a),
        .pc_out(s_a[13]), .pc_inc(s_a[12]), .pc_load(s_a[11]), .mar_load(s_a[10]),
        .ram_out(s_a[9]), .ram_write(s_a[8]), .ir_load(s_a[7]), .ir_out(s_a[6]),
        .a_load(s_a[5]), .a_out(s_a[4]), .b_load(s_a[3]), .alu_out(s_a[2]),
        .alu_sub(s_a[1]), .out_load(s_a[0]), .halt(h_a), .illegal(il_a)
    );

    control_sequencer #(.OP_W(5), .EARLY_END(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .op_code(op5), .zero_flag(zero_flag),
        .t_state(t_b),
        .pc_out(s_b[13]), .pc_inc(s_b[12]), .pc_load(s_b[11]), .mar_load(s_b[10]),
        .ram_out(s_b[9]), .ram_write(s_b[8]), .ir_load(s_b[7]), .ir_out(s_b[6]),
        .a_load(s_b[5]), .a_out(s_b[4]), .b_load(s_b[3]), .alu_out(s_b[2]),
        .alu_sub(s_b[1]), .out_load(s_b[0]), .halt(h_b), .illegal(il_b)
    );

    control_sequencer #(.OP_W(4), .EARLY_END(0)) u_dut_c (
        .clk(clk), .rst(rst), .en(en), .op_code(op5[3:0]), .zero_flag(zero_flag),
        .t_state(t_c),
        .pc_out(s_c[13]), .pc_inc(s_c[12]), .pc_load(s_c[11]), .mar_load(s_c[10]),
        .ram_out(s_c[9]), .ram_write(s_c[8]), .ir_load(s_c[7]), .ir_out(s_c[6]),
        .a_load(s_c[5]), .a_out(s_c[4]), .b_load(s_c[3]), .alu_out(s_c[2]),
        .alu_sub(s_c[1]), .out_load(s_c[0]), .halt(h_c), .illegal(il_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed word: {halt, illegal, t_state, strobes}.
    function automatic logic [21:0] obs(input int sel);
        case (sel)
            0:       return {h_a, il_a, t_a, s_a};
            1:       return {h_b, il_b, t_b, s_b};
            default: return {h_c, il_c, t_c, s_c};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Runs one instruction from T1; the opcode is scrambled during fetch
    // and only presented correctly from T4, then the following T1 is checked.
    task automatic run(input int sel, input string tag, input logic [4:0] op,
                       input logic zf, input int len, input logic il,
                       input logic [13:0] e4, input logic [13:0] e5, input logic [13:0] e6);
        logic [13:0] e;
        op5       = ~op;
        zero_flag = zf;
        for (int k = 0; k < len; k++) begin
            case (k)
                0:       e = c_F1;
                1:       e = c_F2;
                2:       e = c_F3;
                3:       e = e4;
                4:       e = e5;
                default: e = e6;
            endcase
            if (k == 3) op5 = op;
            #1;
            check($sformatf("%s T%0d", tag, k + 1), obs(sel),
                  {1'b0, (il && k == 3), 6'(1 << k), e});
            tick();
        end
        #1;
        check({tag, " next"}, obs(sel), {2'b00, 6'h01, c_F1});
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        zero_flag = 1'b0;
        op5       = 5'h00;
        tick();
        check("reset_a", obs(0), {2'b00, 6'h01, 14'h0});
        check("reset_c", obs(2), {2'b00, 6'h01, 14'h0});
        rst = 1'b0;

        // Early-end configuration, every legal opcode plus an illegal one.
        run(0, "lda",  5'h00, 1'b0, 5, 1'b0, c_IR_OUT | c_MAR_LOAD, c_RAM_OUT | c_A_LOAD, 14'h0);
        run(0, "add",  5'h01, 1'b0, 6, 1'b0, c_IR_OUT | c_MAR_LOAD, c_RAM_OUT | c_B_LOAD,
            c_ALU_OUT | c_A_LOAD);
        run(0, "sub",  5'h02, 1'b0, 6, 1'b0, c_IR_OUT | c_MAR_LOAD, c_RAM_OUT | c_B_LOAD,
            c_ALU_OUT | c_A_LOAD | c_ALU_SUB);
        run(0, "sta",  5'h03, 1'b0, 5, 1'b0, c_IR_OUT | c_MAR_LOAD, c_A_OUT | c_RAM_WRITE, 14'h0);
        run(0, "jmp",  5'h04, 1'b0, 4, 1'b0, c_IR_OUT | c_PC_LOAD, 14'h0, 14'h0);
        run(0, "jz0",  5'h05, 1'b0, 4, 1'b0, 14'h0, 14'h0, 14'h0);
        run(0, "jz1",  5'h05, 1'b1, 4, 1'b0, c_IR_OUT | c_PC_LOAD, 14'h0, 14'h0);
        run(0, "out",  5'h0E, 1'b0, 4, 1'b0, c_A_OUT | c_OUT_LOAD, 14'h0, 14'h0);
        run(0, "ill7", 5'h07, 1'b0, 4, 1'b1, 14'h0, 14'h0, 14'h0);

        // Stall in T2, then reset in the middle of ADD's T5.
        op5 = 5'h01;
        #1;
        check("stall T1", obs(0), {2'b00, 6'h01, c_F1});
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall hold%0d", i), obs(0), {2'b00, 6'h02, 14'h0});
            tick();
        end
        en = 1'b1;
        #1;
        check("stall T2", obs(0), {2'b00, 6'h02, c_F2});
        tick();
        #1;
        check("stall T3", obs(0), {2'b00, 6'h04, c_F3});
        tick();
        #1;
        check("stall T4", obs(0), {2'b00, 6'h08, c_IR_OUT | c_MAR_LOAD});
        tick();
        rst = 1'b1;
        #1;
        check("rst in T5", obs(0), {2'b00, 6'h10, 14'h0});
        tick();
        rst = 1'b0;
        #1;
        check("after rst T5", obs(0), {2'b00, 6'h01, c_F1});

        // HLT: sticky until reset regardless of en and opcode.
        op5 = 5'h0F;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("hlt T%0d", k + 1), obs(0),
                  {2'b00, 6'(1 << k), (k == 0) ? c_F1 : (k == 1) ? c_F2 : (k == 2) ? c_F3 : 14'h0});
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            en  = i[0];
            op5 = 5'($urandom_range(0, 31));
            #1;
            check($sformatf("halted%0d", i), obs(0), {2'b10, 6'h00, 14'h0});
            tick();
        end
        en  = 1'b1;
        rst = 1'b1;
        #1;
        check("halted rst", obs(0), {2'b00, 6'h00, 14'h0});
        tick();
        rst = 1'b0;
        #1;
        check("unhalt", obs(0), {2'b00, 6'h01, c_F1});

        // Five-bit opcode: upper bit set is illegal, zero upper bit decodes.
        do_reset();
        run(1, "ill10", 5'h10, 1'b0, 4, 1'b1, 14'h0, 14'h0, 14'h0);
        run(1, "sub5",  5'h02, 1'b0, 6, 1'b0, c_IR_OUT | c_MAR_LOAD, c_RAM_OUT | c_B_LOAD,
            c_ALU_OUT | c_A_LOAD | c_ALU_SUB);

        // Fixed-length configuration: every instruction spans six cycles.
        do_reset();
        run(2, "out_fix", 5'h0E, 1'b0, 6, 1'b0, c_A_OUT | c_OUT_LOAD, 14'h0, 14'h0);
        run(2, "lda_fix", 5'h00, 1'b0, 6, 1'b0, c_IR_OUT | c_MAR_LOAD, c_RAM_OUT | c_A_LOAD, 14'h0);
        run(2, "ill_fix", 5'h09, 1'b0, 6, 1'b1, 14'h0, 14'h0, 14'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OP_W, default 4, opcode width; the SHALL constraint is OP_W >= 4.
REQ-002 Parameter EARLY_END, default 1; 1 = variable-length instructions, 0 = every instruction runs all six T-states.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  run enable; low freezes the sequencer.
REQ-006 op_code  input  OP_W  opcode from the instruction register; valid from T4.
REQ-007 zero_flag  input  1  accumulator-zero flag.
REQ-008 t_state  output  6  one-hot T-state; bit0 = T1 ... bit5 = T6.
REQ-009 pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write, ir_load, ir_out, a_load, a_out, b_load, alu_out, alu_sub, out_load  output  1 each  datapath control strobes.
REQ-010 halt  output  1  high while halted.
REQ-011 illegal  output  1  one-cycle pulse in T4 of an undefined opcode.

Function
REQ-012 Opcode decoding SHALL apply only when op_code[OP_W-1:4] == 0.
- LDA=0x0, ADD=0x1, SUB=0x2, STA=0x3, JMP=0x4, JZ=0x5, OUT=0xE, HLT=0xF.
- All other values are illegal.
REQ-013 The sequencer SHALL be a one-hot ring T1..T6 plus a HALTED state.
- Advances one step per clk edge with en=1.
- Holds state when en=0.
REQ-014 The fetch cycles SHALL be identical for all opcodes:
- T1: pc_out, mar_load.
- T2: pc_inc.
- T3: ram_out, ir_load.
REQ-015 The execute cycles SHALL be:
- LDA: T4 ir_out+mar_load; T5 ram_out+a_load.
- ADD: T4 ir_out+mar_load; T5 ram_out+b_load; T6 alu_out+a_load.
- SUB: as ADD, with alu_sub also high in T6 only.
- STA: T4 ir_out+mar_load; T5 a_out+ram_write.
- JMP: T4 ir_out+pc_load.
- JZ: T4 ir_out+pc_load only if zero_flag=1; otherwise no strobes.
- OUT: T4 a_out+out_load.
REQ-016 With EARLY_END=1, the state after the last active execute step SHALL be T1.
- Last step: LDA/STA T5; ADD/SUB T6; JMP/JZ/OUT/illegal T4.
- Instruction lengths: 5, 5, 6, 6, 4, 4, 4, 4 cycles.
REQ-017 With EARLY_END=0, every instruction SHALL traverse T1..T6 and wrap T6->T1; unused steps assert no strobes.
REQ-018 In T4, HLT SHALL move to HALTED on the next enabled edge.
- HALTED: halt=1, t_state=0, all strobes 0.
- HALTED persists regardless of en and op_code until rst.
REQ-019 Illegal opcodes SHALL assert illegal for exactly the T4 cycle and no strobes, then behave as REQ-016/017.
REQ-020 All strobes SHALL be combinational decodes of state and op_code, gated low when rst=1, en=0 or halted.
REQ-021 Every strobe SHALL be high for at most one cycle per T-state.
- Never both pc_inc and pc_load.
- Never both ram_out and ram_write.
- Never more than one bus driver among pc_out, ram_out, ir_out, a_out, alu_out.
REQ-022 zero_flag SHALL be sampled combinationally in T4 only.
REQ-023 op_code changes outside T4..T6 SHALL have no effect.

Reset
REQ-024 rst=1 at a clk edge SHALL set state to T1 and clear HALTED, regardless of en or current state, including mid-instruction.
REQ-025 While rst=1, all strobes, halt and illegal SHALL be 0.
REQ-026 On the first cycle after rst falls, t_state SHALL be 000001, with pc_out=mar_load=1 if en=1.

Verification
REQ-027 Reset then LDA (0x0), EARLY_END=1, en=1 -> t_state sequence 01,02,04,08,10,01; T4 ir_out+mar_load, T5 ram_out+a_load.
REQ-028 SUB (0x2) -> T6 shows alu_out=a_load=alu_sub=1; alu_sub=0 in all other cycles.
REQ-029 JZ with zero_flag=0 -> no strobes in T4, back to T1; with zero_flag=1 -> pc_load=ir_out=1 in T4.
REQ-030 HLT (0xF) -> halt=1 from cycle 5 onward for 20 cycles with toggling en/op_code; rst pulse -> t_state=01, halt=0.
REQ-031 Opcode 0x7, and 0x10 with OP_W=5 -> illegal high for one cycle in T4, no strobes; EARLY_END=0 run of OUT -> six-cycle period, strobes only in T4.
REQ-032 en=0 in T2 for 3 cycles -> t_state holds 02 with all strobes 0; rst asserted in T5 of ADD -> next cycle t_state=01, no b_load.
